store_merge_unit: RTL
=====================

# store_merge_unit

Memory-side store path of the multicycle CPU. The writeback mux moves memory data into the register file; this block moves data the other way, from a register into data memory. It turns an `sw`/`sh`/`sb` request into memory write cycles. Sub-word stores do a read-modify-write so that the untouched bytes are preserved. It sits between the control unit and the data memory port, beside the load path.

## Interface

Parameters:
- `MEM_LATENCY`, default 1: cycles from `mem_addr` valid to `mem_rdata` valid. Legal range is 1..4.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  store request; sampled only in IDLE.
- `store_size`  in  2  00 = none, 01 = byte, 10 = halfword, 11 = word.
- `addr`  in  32  byte address of the store.
- `reg_data`  in  32  source register value; the low byte or halfword is used for sub-word stores.
- `mem_rdata`  in  32  memory read data.
- `mem_addr`  out  32  word-aligned memory address, `{addr[31:2],2'b00}`.
- `mem_wdata`  out  32  merged write word.
- `mem_wr`  out  1  memory write enable, one-cycle pulse.
- `busy`  out  1  high while a store is in progress.
- `done`  out  1  one-cycle pulse when the store has completed.
- `misaligned`  out  1  one-cycle pulse when a request is rejected for alignment.

## Operation

- States: IDLE, READ, WRITE, DONE. The state machine is a registered FSM and every output is registered.
- On reset (`reset`=0 at an edge):
  - state goes to IDLE.
  - `mem_addr`, `mem_wdata` = 0.
  - `mem_wr`, `busy`, `done`, `misaligned` = 0.
- IDLE, `start`=1:
  - `store_size`=00: the request is ignored and the FSM stays in IDLE.
  - Misaligned request (halfword with `addr[0]`=1, or word with `addr[1:0]`≠0): `misaligned`=1 for the next cycle, the FSM stays in IDLE, no memory access is made.
  - Otherwise: latch `addr`, `reg_data` and `store_size`; drive `mem_addr`.
    - Word: go to WRITE.
    - Byte or halfword: go to READ and load the wait counter with `MEM_LATENCY`.
- READ:
  - `mem_wr`=0; the counter decrements each cycle.
  - On the edge where the counter reaches 0, capture `mem_rdata` into the merge register and go to WRITE.
- WRITE (`mem_wr`=1 for exactly this cycle). Byte lanes are little-endian: lane k = bits [8k+7:8k].
  - Word: `mem_wdata` = latched `reg_data`.
  - Byte: lane `addr[1:0]` = `reg_data[7:0]`; the other lanes come from the captured word.
  - Halfword: lanes {1,0} when `addr[1]`=0, lanes {3,2} when `addr[1]`=1, take `reg_data[15:0]`; the other lanes come from the captured word.
  - Next state: DONE.
- DONE: `done`=1, `mem_wr`=0, next state IDLE.
- `busy`: high in READ, WRITE and DONE; low in IDLE.
- `start` while busy: ignored, no queuing.
- `mem_addr` holds its value from request latch through DONE.
- Reset mid-operation (any state): outputs and FSM return to reset values at that edge. A write already in flight is not repeated, and none is issued after reset.

## Timing

Cycle 0 is the edge that samples `start`.
- Word store:
  - cycle 1: WRITE (`mem_wr`=1, `busy`=1).
  - cycle 2: DONE (`done`=1).
  - Request to `done` is 2 cycles.
- Byte/halfword store:
  - cycles 1..`MEM_LATENCY`: READ.
  - cycle `MEM_LATENCY`+1: WRITE.
  - cycle `MEM_LATENCY`+2: DONE.
  - With the default `MEM_LATENCY`=1, request to `done` is 3 cycles.
- `mem_rdata` is sampled on the edge that ends the last READ cycle only.
- `misaligned` pulses in cycle 1; `busy` stays 0.
- A new `start` is accepted in the cycle after DONE, so back-to-back word stores run one every 3 cycles.

## Structure

- Package `store_pkg` holds:
  - the `store_size` encodings (`SZ_NONE`, `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`);
  - the FSM state encoding (IDLE, READ, WRITE, DONE).
- Sub-module `byte_lane_merge`: combinational. Inputs are old word, new data, size and offset; output is the merged word. It is shared with future load sign/zero-extension checks.
- The FSM, counter and registers live in `store_merge_unit`.

## Test plan

- Word store: `addr`=0x0000_0010, `reg_data`=0xDEAD_BEEF, size 11 → cycle 1: `mem_wr`=1, `mem_addr`=0x10, `mem_wdata`=0xDEAD_BEEF; cycle 2: `done`=1.
- Byte store: `addr`=0x0000_0013, `reg_data`=0x0000_00AB, `mem_rdata`=0x1122_3344 → `mem_wdata`=0xAB22_3344, `mem_addr`=0x10, `done` at cycle 3.
- Halfword store: `addr`=0x0000_0022, `reg_data`=0xFFFF_CAFE, `mem_rdata`=0x1122_3344 → `mem_wdata`=0xCAFE_3344; repeat with `MEM_LATENCY`=3 → `done` at cycle 5.
- Misaligned requests: word at 0x0000_0002 and halfword at 0x0000_0001 → `misaligned`=1 in cycle 1, `mem_wr` never asserted, `busy`=0.
- Reset mid-operation: assert `reset`=0 in READ → next edge all outputs 0, no `mem_wr`; a later word store completes normally.
- Busy and no-op requests:
  - `start` held high during a byte store → only one write is issued;
  - `store_size`=00 with `start`=1 → no output activity.

Source files
------------

// File: rtl/store_pkg.sv
// Shared encodings for the store path: request sizes and the store FSM states.
package store_pkg;

    typedef enum logic [1:0] {
        SZ_NONE = 2'b00,
        SZ_BYTE = 2'b01,
        SZ_HALF = 2'b10,
        SZ_WORD = 2'b11
    } store_size_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_DONE  = 2'b11
    } store_state_t;

    // Halfwords need an even address, words need a 4-byte aligned address.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        return ((size == SZ_HALF) && offset[0]) ||
               ((size == SZ_WORD) && (offset != 2'b00));
    endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Combinational little-endian byte-lane merge: lanes selected by size/offset
// take the new data, every other lane keeps the old word.
module byte_lane_merge
    import store_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    output logic [31:0] merged
);

    logic [3:0]  lane_en;
    logic [31:0] lane_src;

    // Build per-lane enables and replicate the source so every lane sees its byte.
    always_comb begin
        lane_en  = 4'b0000;
        lane_src = new_data;
        case (size)
            SZ_BYTE: begin
                lane_en  = 4'b0001 << offset;
                lane_src = {4{new_data[7:0]}};
            end
            SZ_HALF: begin
                lane_en  = offset[1] ? 4'b1100 : 4'b0011;
                lane_src = {2{new_data[15:0]}};
            end
            SZ_WORD: begin
                lane_en  = 4'b1111;
                lane_src = new_data;
            end
            default: begin
                lane_en  = 4'b0000;
                lane_src = new_data;
            end
        endcase
    end

    // Pick each lane from the new data or the old word.
    always_comb begin
        merged = old_word;
        for (int k = 0; k < 4; k++) begin
            if (lane_en[k]) merged[8*k +: 8] = lane_src[8*k +: 8];
        end
    end

endmodule

// File: rtl/store_merge_unit.sv
// Store path from register to data memory. Word stores write directly;
// byte/halfword stores read the target word, merge, then write it back.
module store_merge_unit
    import store_pkg::*;
#(
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  store_size,
    input  logic [31:0] addr,
    input  logic [31:0] reg_data,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wr,
    output logic        busy,
    output logic        done,
    output logic        misaligned
);

    localparam logic [2:0] CNT_INIT = 3'(MEM_LATENCY);

    store_state_t state_q, state_d;
    logic [1:0]   off_q, off_d;
    logic [31:0]  data_q, data_d;
    logic [1:0]   size_q, size_d;
    logic [2:0]   cnt_q, cnt_d;
    logic [31:0]  mem_addr_q, mem_addr_d;
    logic [31:0]  mem_wdata_q, mem_wdata_d;
    logic         mem_wr_q, mem_wr_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         misaligned_q, misaligned_d;
    logic [31:0]  merged;

    // Merge against the live read data; it is registered into mem_wdata on the
    // edge that ends the last READ cycle, so that register is the merge register.
    byte_lane_merge u_merge (
        .old_word (mem_rdata),
        .new_data (data_q),
        .size     (size_q),
        .offset   (off_q),
        .merged   (merged)
    );

    // Next-state and next-output logic; all outputs are registered from here.
    always_comb begin
        state_d      = state_q;
        off_d        = off_q;
        data_d       = data_q;
        size_d       = size_q;
        cnt_d        = cnt_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wr_d     = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        misaligned_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && (store_size != SZ_NONE)) begin
                    if (is_misaligned(store_size, addr[1:0])) begin
                        misaligned_d = 1'b1;
                    end else begin
                        off_d      = addr[1:0];
                        data_d     = reg_data;
                        size_d     = store_size;
                        mem_addr_d = {addr[31:2], 2'b00};
                        busy_d     = 1'b1;
                        if (store_size == SZ_WORD) begin
                            state_d     = ST_WRITE;
                            mem_wr_d    = 1'b1;
                            mem_wdata_d = reg_data;
                        end else begin
                            state_d = ST_READ;
                            cnt_d   = CNT_INIT;
                        end
                    end
                end
            end
            ST_READ: begin
                busy_d = 1'b1;
                cnt_d  = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d     = ST_WRITE;
                    mem_wr_d    = 1'b1;
                    mem_wdata_d = merged;
                end
            end
            ST_WRITE: begin
                busy_d  = 1'b1;
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            off_q        <= 2'b00;
            data_q       <= 32'h0;
            size_q       <= 2'b00;
            cnt_q        <= 3'd0;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
            mem_wr_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            off_q        <= off_d;
            data_q       <= data_d;
            size_q       <= size_d;
            cnt_q        <= cnt_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wr_q     <= mem_wr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wr     = mem_wr_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign misaligned = misaligned_q;

endmodule
